// File: rtl/bus_arbiter_2m_if.sv
// Request/grant bundle between the two bus masters and the bus_arbiter_2m arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_2m_if;
  logic m1_request;
  logic m2_request;
  logic m1_grant;
  logic m2_grant;
  logic bus_sel;
  logic bus_busy;
  logic preempt;

  modport master (
    output m1_request, m2_request,
    input  m1_grant, m2_grant, bus_sel, bus_busy, preempt
  );

  modport slave (
    input  m1_request, m2_request,
    output m1_grant, m2_grant, bus_sel, bus_busy, preempt
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter with hold-timeout preemption and a dead cycle on every handover.
// Optional ARB_ROUND_ROBIN_EN: ties go to the master that did not own the last tenure.
module bus_arbiter_2m #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  bus_arbiter_2m_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, G1 = 2'd1, G2 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             m1_grant_r, m2_grant_r, bus_sel_r, bus_busy_r, preempt_r;
  logic             pre_vld, pre_m2;
  logic             tie_m2, pick_m2, any_req, own_req, rival_req, timeout;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m2;
  assign tie_m2 = ~last_m2;
`else
  assign tie_m2 = 1'b0;
`endif

  always_comb begin
    any_req   = bus.m1_request | bus.m2_request;
    own_req   = (state == G2) ? bus.m2_request : bus.m1_request;
    rival_req = (state == G2) ? bus.m1_request : bus.m2_request;
    timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && rival_req;
    // A preempted master's rival goes first; otherwise tie rule, else whoever asks.
    if (pre_vld && pre_m2 && bus.m1_request)
      pick_m2 = 1'b0;
    else if (pre_vld && !pre_m2 && bus.m2_request)
      pick_m2 = 1'b1;
    else if (bus.m1_request && bus.m2_request)
      pick_m2 = tie_m2;
    else
      pick_m2 = bus.m2_request;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      m1_grant_r <= 1'b0;
      m2_grant_r <= 1'b0;
      bus_sel_r  <= 1'b0;
      bus_busy_r <= 1'b0;
      preempt_r  <= 1'b0;
      pre_vld    <= 1'b0;
      pre_m2     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m2    <= 1'b1;
`endif
    end else begin
      preempt_r <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= pick_m2 ? G2 : G1;
            m1_grant_r <= ~pick_m2;
            m2_grant_r <= pick_m2;
            bus_sel_r  <= pick_m2;
            bus_busy_r <= 1'b1;
            hold_cnt   <= '0;
            pre_vld    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_m2    <= pick_m2;
`endif
          end
        end
        default: begin
          // A release by the owner takes precedence over a coincident timeout.
          if (!own_req || timeout) begin
            state      <= IDLE;
            m1_grant_r <= 1'b0;
            m2_grant_r <= 1'b0;
            bus_busy_r <= 1'b0;
            if (own_req) begin
              preempt_r <= 1'b1;
              pre_vld   <= 1'b1;
              pre_m2    <= (state == G2);
            end
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.m1_grant = m1_grant_r;
  assign bus.m2_grant = m2_grant_r;
  assign bus.bus_sel  = bus_sel_r;
  assign bus.bus_busy = bus_busy_r;
  assign bus.preempt  = preempt_r;
endmodule
